playback_ctrl_fsm: RTL and testbench

Parametrised keyboard-driven playback controller for the audio player. It decodes strobed ASCII key codes into play, pause, direction, restart and playback-speed commands. It drives the flash address generator with `start_reading`, `direction`, a restart request/acknowledge handshake and a sample-rate divider value. It supersedes the fixed, level-sensitive playback FSM: every key acts exactly once, per `key_valid` strobe.

---
 rtl/playback_ctrl_fsm_pkg.sv | 77 +++++++
 rtl/playback_ctrl_fsm_key_decode.sv | 35 +++
 rtl/playback_ctrl_fsm.sv | 106 ++++++++++
 tb/tb_playback_ctrl_fsm.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/playback_ctrl_fsm_pkg.sv
//------------------------------------------------------------------------------
// playback_pkg : states, key codes, commands and next-state rule for playback.
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package playback_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FWD_PLAY  = 3'd1,
    FWD_PAUSE = 3'd2,
    BWD_PLAY  = 3'd3,
    BWD_PAUSE = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    PLAY    = 3'd1,
    PAUSE   = 3'd2,
    BACK    = 3'd3,
    FWD     = 3'd4,
    RESTART = 3'd5,
    FASTER  = 3'd6,
    SLOWER  = 3'd7
  } cmd_t;

  localparam logic [7:0] KEY_E    = 8'h45;
  localparam logic [7:0] KEY_E_LC = 8'h65;
  localparam logic [7:0] KEY_D    = 8'h44;
  localparam logic [7:0] KEY_D_LC = 8'h64;
  localparam logic [7:0] KEY_B    = 8'h42;
  localparam logic [7:0] KEY_B_LC = 8'h62;
  localparam logic [7:0] KEY_F    = 8'h46;
  localparam logic [7:0] KEY_F_LC = 8'h66;
  localparam logic [7:0] KEY_R    = 8'h52;
  localparam logic [7:0] KEY_R_LC = 8'h72;
`ifdef PLAYBACK_SPEED_CTRL_EN
  localparam logic [7:0] KEY_U    = 8'h55;
  localparam logic [7:0] KEY_U_LC = 8'h75;
  localparam logic [7:0] KEY_L    = 8'h4C;
  localparam logic [7:0] KEY_L_LC = 8'h6C;
`endif

  // Unlisted command/state pairs hold; unused encodings recover to IDLE.
  function automatic state_t next_state(input state_t s, input cmd_t c);
    state_t n;
    n = s;
    case (s)
      IDLE: begin
        if (c == PLAY)       n = FWD_PLAY;
        else if (c == BACK)  n = BWD_PAUSE;
      end
      FWD_PLAY: begin
        if (c == BACK)       n = BWD_PLAY;
        else if (c == PAUSE) n = FWD_PAUSE;
      end
      BWD_PLAY: begin
        if (c == FWD)        n = FWD_PLAY;
        else if (c == PAUSE) n = BWD_PAUSE;
      end
      FWD_PAUSE: begin
        if (c == PLAY)       n = FWD_PLAY;
        else if (c == BACK)  n = BWD_PAUSE;
      end
      BWD_PAUSE: begin
        if (c == PLAY)       n = BWD_PLAY;
        else if (c == FWD)   n = FWD_PAUSE;
      end
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/playback_ctrl_fsm_key_decode.sv
//------------------------------------------------------------------------------
// key_decode : strobed ASCII key to playback command (case-insensitive).
// U/L speed keys decode only with PLAYBACK_SPEED_CTRL_EN.   Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module key_decode
  import playback_pkg::*;
(
  input  logic       key_valid,
  input  logic [7:0] keyboard,
  output logic [2:0] cmd
);

  always_comb begin
    cmd = NONE;
    if (key_valid) begin
      case (keyboard)
        KEY_E, KEY_E_LC: cmd = PLAY;
        KEY_D, KEY_D_LC: cmd = PAUSE;
        KEY_B, KEY_B_LC: cmd = BACK;
        KEY_F, KEY_F_LC: cmd = FWD;
        KEY_R, KEY_R_LC: cmd = RESTART;
`ifdef PLAYBACK_SPEED_CTRL_EN
        KEY_U, KEY_U_LC: cmd = FASTER;
        KEY_L, KEY_L_LC: cmd = SLOWER;
`endif
        default:         cmd = NONE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/playback_ctrl_fsm.sv
//------------------------------------------------------------------------------
// playback_ctrl_fsm : keyboard playback FSM, restart handshake, speed divider.
// Speed keys enabled by PLAYBACK_SPEED_CTRL_EN.              Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module playback_ctrl_fsm
  import playback_pkg::*;
#(
  parameter int SPEED_W     = 8,
  parameter int DIV_DEFAULT = 16,
  parameter int DIV_MIN     = 4,
  parameter int DIV_MAX     = 64,
  parameter int DIV_STEP    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [7:0]         keyboard,
  input  logic               restart_ack,
  output logic               start_reading,
  output logic               direction,
  output logic               restart_req,
  output logic [SPEED_W-1:0] speed_div,
  output logic [2:0]         state
);

  if (!(DIV_MIN <= DIV_DEFAULT && DIV_DEFAULT <= DIV_MAX &&
        DIV_MAX < (1 << SPEED_W) && DIV_STEP > 0)) begin : g_bad_cfg
    $error("playback_ctrl_fsm: illegal speed divider configuration");
  end

  logic [2:0] cmd_raw;
  cmd_t       cmd;
  state_t     state_q;
  state_t     state_nxt;

  key_decode u_key_decode (
    .key_valid (key_valid),
    .keyboard  (keyboard),
    .cmd       (cmd_raw)
  );

  assign cmd       = cmd_t'(cmd_raw);
  assign state_nxt = next_state(state_q, cmd);
  assign state     = state_q;

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      start_reading <= 1'b0;
      direction     <= 1'b1;
    end else begin
      state_q       <= state_nxt;
      start_reading <= (state_nxt == FWD_PLAY) || (state_nxt == BWD_PLAY);
      direction     <= !((state_nxt == BWD_PLAY) || (state_nxt == BWD_PAUSE));
    end
  end

  // An ack always wins, which also drops a RESTART key in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      restart_req <= 1'b0;
    end else if (restart_ack) begin
      restart_req <= 1'b0;
    end else if (cmd == RESTART && state_q != IDLE) begin
      restart_req <= 1'b1;
    end
  end

`ifdef PLAYBACK_SPEED_CTRL_EN
  localparam logic [SPEED_W:0]   STEP_X = (SPEED_W+1)'(DIV_STEP);
  localparam logic [SPEED_W:0]   MIN_X  = (SPEED_W+1)'(DIV_MIN);
  localparam logic [SPEED_W:0]   MAX_X  = (SPEED_W+1)'(DIV_MAX);
  localparam logic [SPEED_W-1:0] DEF    = SPEED_W'(DIV_DEFAULT);

  logic [SPEED_W:0] faster_x;
  logic [SPEED_W:0] slower_x;

  // Guard bit flags a borrow on the way down and absorbs a carry on the way up.
  assign faster_x = {1'b0, speed_div} - STEP_X;
  assign slower_x = {1'b0, speed_div} + STEP_X;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_div <= DEF;
    end else if (cmd == FASTER) begin
      if (faster_x[SPEED_W] || faster_x < MIN_X)
        speed_div <= MIN_X[SPEED_W-1:0];
      else
        speed_div <= faster_x[SPEED_W-1:0];
    end else if (cmd == SLOWER) begin
      if (slower_x > MAX_X)
        speed_div <= MAX_X[SPEED_W-1:0];
      else
        speed_div <= slower_x[SPEED_W-1:0];
    end
  end
`else
  assign speed_div = SPEED_W'(DIV_DEFAULT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_playback_ctrl_fsm.sv
//------------------------------------------------------------------------------
// tb_playback_ctrl_fsm : directed and randomized checks of playback_ctrl_fsm.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_playback_ctrl_fsm;

  localparam int SPEED_W     = 8;
  localparam int DIV_DEFAULT = 16;
  localparam int DIV_MIN     = 4;
  localparam int DIV_MAX     = 64;
  localparam int DIV_STEP    = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               key_valid;
  logic [7:0]         keyboard;
  logic               restart_ack;
  logic               start_reading;
  logic               direction;
  logic               restart_req;
  logic [SPEED_W-1:0] speed_div;
  logic [2:0]         state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: playback as idle / playing / forward flags.
  bit m_idle, m_play, m_fwd, m_req;
  int m_speed;

  always #5 clk = ~clk;

  playback_ctrl_fsm #(
    .SPEED_W     (SPEED_W),
    .DIV_DEFAULT (DIV_DEFAULT),
    .DIV_MIN     (DIV_MIN),
    .DIV_MAX     (DIV_MAX),
    .DIV_STEP    (DIV_STEP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_valid     (key_valid),
    .keyboard      (keyboard),
    .restart_ack   (restart_ack),
    .start_reading (start_reading),
    .direction     (direction),
    .restart_req   (restart_req),
    .speed_div     (speed_div),
    .state         (state)
  );

  function automatic int exp_state();
    if (m_idle) return 0;
    if (m_fwd)  return m_play ? 1 : 2;
    return m_play ? 3 : 4;
  endfunction

  // 0 none, 1 play, 2 pause, 3 back, 4 fwd, 5 restart, 6 faster, 7 slower
  function automatic int key_cmd(input logic [7:0] k);
    logic [7:0] u;
    u = (k >= 8'h61 && k <= 8'h7A) ? k - 8'd32 : k;
    case (u)
      8'h45: return 1;
      8'h44: return 2;
      8'h42: return 3;
      8'h46: return 4;
      8'h52: return 5;
`ifdef PLAYBACK_SPEED_CTRL_EN
      8'h55: return 6;
      8'h4C: return 7;
`endif
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_idle = 1; m_play = 0; m_fwd = 1; m_req = 0; m_speed = DIV_DEFAULT;
  endtask

  task automatic model_step(input logic v, input logic [7:0] k, input logic ack);
    int c;
    c = v ? key_cmd(k) : 0;
    if (ack)                     m_req = 0;
    else if (c == 5 && !m_idle)  m_req = 1;
    case (c)
      1: begin m_idle = 0; m_play = 1; end
      2: if (!m_idle) m_play = 0;
      3: begin
        if (m_idle) begin m_idle = 0; m_play = 0; end
        m_fwd = 0;
      end
      4: if (!m_idle) m_fwd = 1;
      6: m_speed = (m_speed - DIV_STEP < DIV_MIN) ? DIV_MIN : m_speed - DIV_STEP;
      7: m_speed = (m_speed + DIV_STEP > DIV_MAX) ? DIV_MAX : m_speed + DIV_STEP;
      default: ;
    endcase
  endtask

  // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic v, input logic [7:0] k, input logic ack);
    @(negedge clk);
    key_valid = v; keyboard = k; restart_ack = ack;
    @(posedge clk);
    model_step(v, k, ack);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; key_valid = 1'b0; keyboard = 8'h00; restart_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++;
    if (start_reading !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", start_reading); end
    n_checks++;
    if (direction !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b expected 1", direction); end
    n_checks++;
    if (restart_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", restart_req); end
    n_checks++;
    if (speed_div !== SPEED_W'(DIV_DEFAULT)) begin
      n_fail++; $display("FAIL reset_speed: got %0d expected %0d", speed_div, DIV_DEFAULT);
    end
  endtask

  task automatic test_play_hold();
    drive(1'b1, 8'h45, 1'b0);
    n_checks++;
    if ({state, start_reading, direction} !== {3'd1, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL play: got st=%0d sr=%b dir=%b expected st=1 sr=1 dir=1", state, start_reading, direction);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h45, 1'b0);
    n_checks++;
    if ({state, start_reading, direction} !== {3'd1, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL hold_no_strobe: got st=%0d sr=%b dir=%b expected st=1 sr=1 dir=1", state, start_reading, direction);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'h62, 1'b0);
    n_checks++;
    if ({state, start_reading, direction} !== {3'd3, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL back_play: got st=%0d sr=%b dir=%b expected st=3 sr=1 dir=0", state, start_reading, direction);
    end
    drive(1'b1, 8'h64, 1'b0);
    n_checks++;
    if ({state, start_reading, direction} !== {3'd4, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL back_pause: got st=%0d sr=%b dir=%b expected st=4 sr=0 dir=0", state, start_reading, direction);
    end
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_restart();
    drive(1'b1, 8'h65, 1'b0);
    drive(1'b1, 8'h52, 1'b0);
    n_checks++;
    if ({state, restart_req} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL restart_set: got st=%0d req=%b expected st=3 req=1", state, restart_req);
    end
    drive(1'b1, 8'h72, 1'b0);
    n_checks++;
    if ({state, restart_req} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL restart_pending: got st=%0d req=%b expected st=3 req=1", state, restart_req);
    end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (restart_req !== 1'b0) begin n_fail++; $display("FAIL restart_ack: got %b expected 0", restart_req); end
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h52, 1'b1);
    n_checks++;
    if (restart_req !== 1'b0) begin n_fail++; $display("FAIL restart_with_ack: got %b expected 0", restart_req); end
    drive(1'b0, 8'h00, 1'b1);
    n_checks++;
    if ({state, restart_req} !== {3'd3, 1'b0}) begin
      n_fail++; $display("FAIL stray_ack: got st=%0d req=%b expected st=3 req=0", state, restart_req);
    end
  endtask

  task automatic test_speed();
`ifdef PLAYBACK_SPEED_CTRL_EN
    for (int i = 0; i < 6; i++) drive(1'b1, (i % 2 == 0) ? 8'h55 : 8'h75, 1'b0);
    n_checks++;
    if (speed_div !== 8'd4) begin n_fail++; $display("FAIL faster_reach_min: got %0d expected 4", speed_div); end
    drive(1'b1, 8'h55, 1'b0);
    n_checks++;
    if (speed_div !== 8'd4) begin n_fail++; $display("FAIL faster_sat: got %0d expected 4", speed_div); end
    for (int i = 0; i < 30; i++) drive(1'b1, (i % 2 == 0) ? 8'h4C : 8'h6C, 1'b0);
    n_checks++;
    if (speed_div !== 8'd64) begin n_fail++; $display("FAIL slower_reach_max: got %0d expected 64", speed_div); end
    drive(1'b1, 8'h4C, 1'b0);
    n_checks++;
    if ({state, speed_div} !== {3'd3, 8'd64}) begin
      n_fail++; $display("FAIL slower_sat: got st=%0d speed=%0d expected st=3 speed=64", state, speed_div);
    end
`else
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h4C, 1'b0);
    drive(1'b1, 8'h75, 1'b0);
    n_checks++;
    if ({state, speed_div} !== {3'd3, 8'd16}) begin
      n_fail++; $display("FAIL speed_disabled: got st=%0d speed=%0d expected st=3 speed=16", state, speed_div);
    end
`endif
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'h46, 1'b0);
    drive(1'b1, 8'h52, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    n_checks++;
    if ({state, restart_req} !== {3'd1, 1'b1}) begin
      n_fail++; $display("FAIL pre_reset: got st=%0d req=%b expected st=1 req=1", state, restart_req);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({state, start_reading, direction, restart_req, speed_div} !== {3'd0, 1'b0, 1'b1, 1'b0, 8'd16}) begin
      n_fail++; $display("FAIL async_reset: got st=%0d sr=%b dir=%b req=%b speed=%0d expected 0/0/1/0/16",
                         state, start_reading, direction, restart_req, speed_div);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 8'h52, 1'b0);
    n_checks++;
    if ({state, restart_req} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL restart_in_idle: got st=%0d req=%b expected st=0 req=0", state, restart_req);
    end
    drive(1'b1, 8'h62, 1'b0);
    n_checks++;
    if ({state, start_reading, direction} !== {3'd4, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL idle_back: got st=%0d sr=%b dir=%b expected st=4 sr=0 dir=0", state, start_reading, direction);
    end
  endtask

  task automatic test_random();
    logic [7:0] keys [16];
    logic [7:0] k;
    logic       v, ack;
    logic [13:0] got, exp;
    keys = '{8'h45, 8'h65, 8'h44, 8'h64, 8'h42, 8'h62, 8'h46, 8'h66,
             8'h52, 8'h72, 8'h55, 8'h75, 8'h4C, 8'h6C, 8'h41, 8'h00};
    for (int i = 0; i < 500; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      k   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : keys[$urandom_range(0, 15)];
      ack = ($urandom_range(0, 7) == 0);
      drive(v, k, ack);
      got = {state, start_reading, direction, restart_req, speed_div};
      exp = {3'(exp_state()), (!m_idle && m_play), m_fwd, m_req, 8'(m_speed)};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] key=%h v=%b ack=%b: got st=%0d sr=%b dir=%b req=%b spd=%0d expected st=%0d sr=%b dir=%b req=%b spd=%0d",
                 i, k, v, ack, got[13:11], got[10], got[9], got[8], got[7:0],
                 exp[13:11], exp[10], exp[9], exp[8], exp[7:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_play_hold();
    test_back_to_back();
    test_restart();
    test_speed();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
